// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing a single-accumulator datapath.
// Ports: clock, reset (async, active-high); ir_out (IR contents, opcode in
// ir_out[OPW-1:0]); z (AC==0 flag, used only in JMPZ); control (23-bit
// datapath control word); state (current encoding, debug); halted (in HALT).
module control_unit #(
    parameter int OPW = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir_out,
    input  logic        z,
    output logic [22:0] control,
    output logic [4:0]  state,
    output logic        halted
);
    localparam logic [4:0] FETCH1 = 5'd0,  FETCH2 = 5'd1,  DECODE = 5'd2,
                           LDAC1  = 5'd3,  LDAC2  = 5'd4,  LDAC3  = 5'd5,
                           STAC1  = 5'd6,  STAC2  = 5'd7,  STAC3  = 5'd8,
                           MVACR  = 5'd9,  MVRAC  = 5'd10, ADD    = 5'd11,
                           SUB    = 5'd12, INAC   = 5'd13, CLAC   = 5'd14,
                           JUMP1  = 5'd15, JMPZ   = 5'd16, JSKIP  = 5'd17,
                           HALT   = 5'd18;
    localparam logic [3:0] B_PC = 4'd2, B_DR = 4'd4, B_R = 4'd5, B_AC = 4'd6,
                           B_DRAM = 4'd7, B_IRAM = 4'd8;
    localparam int PC_INC = 10, DRAM_WR = 13, R_LD = 14, AR_LD = 15, DR_LD = 16,
                   AC_LD = 17, PC_LD = 18, IR_LD = 19, ADDR_AR = 20, AC_ALU = 22;
    logic [4:0]     state_q, state_d;
    logic [OPW-1:0] opcode;
    assign opcode = ir_out[OPW-1:0];
    if (OPW < 16) begin : g_unused
        logic unused_ir_hi;
        assign unused_ir_hi = ^ir_out[15:OPW];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FETCH1;
        else       state_q <= state_d;
    end
    // Unused encodings fall through to the default and recover to FETCH1.
    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OPW'(8'h01): state_d = LDAC1;
                    OPW'(8'h02): state_d = STAC1;
                    OPW'(8'h03): state_d = MVACR;
                    OPW'(8'h04): state_d = MVRAC;
                    OPW'(8'h05): state_d = ADD;
                    OPW'(8'h06): state_d = SUB;
                    OPW'(8'h07): state_d = INAC;
                    OPW'(8'h08): state_d = CLAC;
                    OPW'(8'h09): state_d = JUMP1;
                    OPW'(8'h0A): state_d = JMPZ;
                    OPW'(8'hFF): state_d = HALT;
                    default:     state_d = FETCH1;
                endcase
            end
            LDAC1:   state_d = LDAC2;
            LDAC2:   state_d = LDAC3;
            STAC1:   state_d = STAC2;
            STAC2:   state_d = STAC3;
            JMPZ:    state_d = z ? JUMP1 : JSKIP;
            HALT:    state_d = HALT;
            default: state_d = FETCH1;
        endcase
    end
    // Address source PC and ALU op ADD are both encoded as zero, so they need no assignment.
    always_comb begin
        control = '0;
        case (state_q)
            FETCH1: begin control[3:0] = B_PC; control[AR_LD] = 1'b1; end
            FETCH2: begin control[3:0] = B_IRAM; control[IR_LD] = 1'b1; control[PC_INC] = 1'b1; end
            LDAC1, STAC1: begin
                control[3:0] = B_IRAM; control[AR_LD] = 1'b1; control[PC_INC] = 1'b1;
            end
            LDAC2: begin control[ADDR_AR] = 1'b1; control[3:0] = B_DRAM; control[DR_LD] = 1'b1; end
            LDAC3: begin control[3:0] = B_DR; control[AC_LD] = 1'b1; end
            STAC2: begin control[3:0] = B_AC; control[DR_LD] = 1'b1; end
            STAC3: begin control[ADDR_AR] = 1'b1; control[3:0] = B_DR; control[DRAM_WR] = 1'b1; end
            MVACR: begin control[3:0] = B_AC; control[R_LD] = 1'b1; end
            MVRAC: begin control[3:0] = B_R; control[AC_LD] = 1'b1; end
            ADD:   begin control[3:0] = B_R; control[AC_LD] = 1'b1; control[AC_ALU] = 1'b1; end
            SUB: begin
                control[3:0] = B_R; control[9:8] = 2'b01; control[AC_LD] = 1'b1; control[AC_ALU] = 1'b1;
            end
            INAC:  begin control[9:8] = 2'b11; control[AC_LD] = 1'b1; control[AC_ALU] = 1'b1; end
            // AC loaded from an undriven bus: the datapath reads that as zero.
            CLAC:  control[AC_LD] = 1'b1;
            JUMP1: begin control[3:0] = B_IRAM; control[PC_LD] = 1'b1; end
            JSKIP: control[PC_INC] = 1'b1;
            default: control = '0;
        endcase
    end
    assign state  = state_q;
    assign halted = (state_q == HALT);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized check of control_unit against an instruction-level plan model.
module tb_control_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        z = 1'b0;
    logic [15:0] ir_out = 16'h0000;
    logic [22:0] control;
    logic [4:0]  state;
    logic        halted;
    int n_chk = 0;
    int n_fail = 0;

    control_unit #(.OPW(8)) dut (
        .clock(clock), .reset(reset), .ir_out(ir_out), .z(z),
        .control(control), .state(state), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef enum logic [4:0] {
        S_F1 = 5'd0, S_F2, S_DEC, S_LD1, S_LD2, S_LD3, S_ST1, S_ST2, S_ST3,
        S_MVACR, S_MVRAC, S_ADD, S_SUB, S_INAC, S_CLAC, S_JUMP1, S_JMPZ, S_JSKIP, S_HALT
    } st_t;

    localparam int PCI = 1 << 10, DW = 1 << 13, RL = 1 << 14, AR = 1 << 15, DR = 1 << 16,
                   AC = 1 << 17, PCL = 1 << 18, IR = 1 << 19;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] f(input int bus, input int alu, input int addr_ar,
                                      input int ac_alu, input int strobes);
        logic [22:0] c;
        c = 23'(strobes);
        c[3:0] = 4'(bus);
        c[9:8] = 2'(alu);
        c[20] = addr_ar[0];
        c[22] = ac_alu[0];
        return c;
    endfunction

    function automatic logic [22:0] exp_ctrl(input st_t s);
        case (s)
            S_F1:         return f(2, 0, 0, 0, AR);
            S_F2:         return f(8, 0, 0, 0, IR | PCI);
            S_LD1, S_ST1: return f(8, 0, 0, 0, AR | PCI);
            S_LD2:        return f(7, 0, 1, 0, DR);
            S_LD3:        return f(4, 0, 0, 0, AC);
            S_ST2:        return f(6, 0, 0, 0, DR);
            S_ST3:        return f(4, 0, 1, 0, DW);
            S_MVACR:      return f(6, 0, 0, 0, RL);
            S_MVRAC:      return f(5, 0, 0, 0, AC);
            S_ADD:        return f(5, 0, 0, 1, AC);
            S_SUB:        return f(5, 1, 0, 1, AC);
            S_INAC:       return f(0, 3, 0, 1, AC);
            S_CLAC:       return f(0, 0, 0, 0, AC);
            S_JUMP1:      return f(8, 0, 0, 0, PCL);
            S_JSKIP:      return f(0, 0, 0, 0, PCI);
            default:      return 23'h0;
        endcase
    endfunction

    function automatic int exp_len(input logic [7:0] op);
        if (op == 8'h01 || op == 8'h02) return 6;
        if (op >= 8'h03 && op <= 8'h09) return 4;
        if (op == 8'h0A) return 5;
        return 3;
    endfunction

    st_t        m_state = S_F1;
    st_t        plan[$];
    logic [7:0] m_op = 8'h00;
    bit         have_op = 0;
    bit         rst_seen = 0;

    // Model: each instruction is a list of states queued at DECODE; an empty plan means fetch.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_state = S_F1;
            plan.delete();
            plan.push_back(S_F2);
            plan.push_back(S_DEC);
            have_op = 0;
            rst_seen = 1;
        end else if (m_state != S_HALT) begin
            if (m_state == S_DEC) begin
                m_op = ir_out[7:0];
                have_op = 1;
                plan.delete();
                case (m_op)
                    8'h01: begin plan.push_back(S_LD1); plan.push_back(S_LD2); plan.push_back(S_LD3); end
                    8'h02: begin plan.push_back(S_ST1); plan.push_back(S_ST2); plan.push_back(S_ST3); end
                    8'h03: plan.push_back(S_MVACR);
                    8'h04: plan.push_back(S_MVRAC);
                    8'h05: plan.push_back(S_ADD);
                    8'h06: plan.push_back(S_SUB);
                    8'h07: plan.push_back(S_INAC);
                    8'h08: plan.push_back(S_CLAC);
                    8'h09: plan.push_back(S_JUMP1);
                    8'h0A: plan.push_back(S_JMPZ);
                    8'hFF: plan.push_back(S_HALT);
                    default: ;
                endcase
            end
            if (m_state == S_JMPZ) plan.push_back(z ? S_JUMP1 : S_JSKIP);
            if (plan.size() == 0) begin
                plan.push_back(S_F1);
                plan.push_back(S_F2);
                plan.push_back(S_DEC);
            end
            m_state = plan.pop_front();
        end
    end

    // Compare every cycle, plus instruction length measured on the DUT's own state.
    int ilen = 0;
    initial forever begin
        @(negedge clock);
        chk("state", 32'(state), 32'(m_state));
        chk("control", 32'(control), 32'(exp_ctrl(m_state)));
        chk("halted", 32'(halted), 32'(m_state == S_HALT));
        if (rst_seen) begin
            ilen = 0;
            rst_seen = 0;
        end
        if (state == 5'd0) begin
            if (ilen > 0 && have_op) chk("cycles", ilen, exp_len(m_op));
            ilen = 1;
        end else if (ilen > 0) ilen++;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_ctrl", 32'(control), 32'h8002);
        chk("rst_halted", 32'(halted), 0);
        step();
        reset = 1'b0;
    endtask

    int halt_cnt = 0;
    initial begin
        #1 reset = 1'b1;
        #1;
        chk("por_state", 32'(state), 0);
        chk("por_ctrl", 32'(control), 32'h8002);
        chk("por_halted", 32'(halted), 0);
        repeat (2) step();
        reset = 1'b0;
        ir_out = 16'h0000;
        step(); chk("nop_f2_state", 32'(state), 1); chk("nop_f2_ctrl", 32'(control), 32'h80408);
        step(); chk("nop_dec_state", 32'(state), 2); chk("nop_dec_ctrl", 32'(control), 0);
        step(); chk("nop_end_state", 32'(state), 0);
        ir_out = 16'h0001;
        repeat (3) step();
        chk("ldac1_state", 32'(state), 3);
        step(); chk("ldac2_state", 32'(state), 4); chk("ldac2_ctrl", 32'(control), 32'h110007);
        step(); chk("ldac3_state", 32'(state), 5); chk("ldac3_ctrl", 32'(control), 32'h20004);
        step(); chk("ldac_end_state", 32'(state), 0);
        ir_out = 16'h000A; z = 1'b0;
        repeat (3) step();
        chk("jmpz_state", 32'(state), 16);
        step(); chk("jskip_state", 32'(state), 17); chk("jskip_ctrl", 32'(control), 32'h400);
        step(); chk("jskip_end", 32'(state), 0);
        z = 1'b1;
        repeat (4) step();
        chk("jump1_state", 32'(state), 15); chk("jump1_ctrl", 32'(control), 32'h40008);
        step(); chk("jump_end", 32'(state), 0);
        ir_out = 16'h0042; z = 1'b0;
        step(); step(); chk("undef_dec_ctrl", 32'(control), 0);
        step(); chk("undef_end_state", 32'(state), 0);
        ir_out = 16'h00FF;
        repeat (3) step();
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", 32'(state), 18);
            chk("halt_flag", 32'(halted), 1);
            chk("halt_ctrl", 32'(control), 0);
            step();
        end
        pulse_reset();
        ir_out = 16'h0002;
        repeat (5) step();
        chk("stac3_ctrl", 32'(control), 32'h102004);
        reset = 1'b1;
        #1;
        chk("stac3_rst_state", 32'(state), 0);
        chk("stac3_rst_wr", 32'(control[13]), 0);
        step();
        reset = 1'b0;
        step(); chk("post_rst_f2", 32'(state), 1);
        for (int i = 0; i < 3000; i++) begin
            automatic int r = int'($urandom_range(0, 99));
            ir_out = 16'($urandom);
            ir_out[7:0] = r < 85 ? 8'($urandom_range(0, 10)) : r < 97 ? 8'($urandom) : 8'hFF;
            z = 1'($urandom);
            if (m_state == S_HALT && ++halt_cnt >= 5) begin
                halt_cnt = 0;
                pulse_reset();
            end else if ($urandom_range(0, 149) == 0) pulse_reset();
            else step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
